// File: rtl/mux4_burst_arbiter.sv
// Round-robin, burst-locking arbiter owning the select of a shared 4:1 data mux,
// with a registered valid/ready output stage toward the downstream consumer.
module mux4_burst_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [3:0]        last,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic              out_ready,
  output logic [3:0]        gnt,
  output logic [3:0]        ack,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic [1:0]        out_src
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  state_t              state, state_nxt;
  logic [3:0]          gnt_nxt;
  logic [1:0]          sel_nxt, ptr, ptr_nxt, scan_idx;
  logic [7:0]          timer, timer_nxt;
  logic                load, found;
  logic [DATA_W-1:0]   mux_data;

  always_comb begin
    case (sel)
      2'd0:    mux_data = data_in1;
      2'd1:    mux_data = data_in2;
      2'd2:    mux_data = data_in3;
      default: mux_data = data_in4;
    endcase
  end

  // The output register can take a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  always_comb begin
    ack = '0;
    if (state == BURST && req[sel] && load) ack[sel] = 1'b1;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    timer_nxt = timer;
    found     = 1'b0;
    scan_idx  = ptr;
    case (state)
      IDLE: begin
        if (|req) begin
          for (int i = 0; i < 4; i++) begin
            scan_idx = ptr + 2'(i);
            if (!found && req[scan_idx]) begin
              found   = 1'b1;
              sel_nxt = scan_idx;
            end
          end
          gnt_nxt   = 4'b0001 << sel_nxt;
          state_nxt = BURST;
          timer_nxt = '0;
        end
      end
      BURST: begin
        if (ack[sel]) begin
          timer_nxt = '0;
          if (last[sel]) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            ptr_nxt   = sel + 2'd1;
          end
        end else if (!req[sel]) begin
          // Stall only counts while the owner has nothing to offer, not under backpressure.
          timer_nxt = timer + 8'd1;
          if (timer_nxt >= TIMEOUT_W) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            ptr_nxt   = sel + 2'd1;
            timer_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (load) begin
      if (|ack) begin
        out_data  <= mux_data;
        out_last  <= last[sel];
        out_src   <= sel;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux4_burst_arbiter.sv
// Directed self-checking bench for mux4_burst_arbiter: reset, single-beat, round-robin,
// burst lock, backpressure, stall timeout and reset in the middle of a burst.
module tb_mux4_burst_arbiter;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req, last;
  logic [DATA_W-1:0] din [4];
  logic              out_ready;
  logic [3:0]        gnt, ack;
  logic [1:0]        sel, out_src;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;

  int n_checks = 0;
  int n_fails  = 0;

  mux4_burst_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_in1  (din[0]),
    .data_in2  (din[1]),
    .data_in3  (din[2]),
    .data_in4  (din[3]),
    .out_ready (out_ready),
    .gnt       (gnt),
    .ack       (ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_sel", sel, 2'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_src", out_src, 2'd0);
    check("rst_ack", ack, 4'b0000);
    rst_n = 1'b1;
    tick();
    check("idle_no_req_gnt", gnt, 4'b0000);

    // Single-beat burst from requester 3
    req = 4'b1000; last = 4'b1000; din[3] = 32'hDEADBEEF;
    #1;
    check("sb_idle_ack", ack, 4'b0000);
    tick();
    check("sb_gnt", gnt, 4'b1000);
    check("sb_sel", sel, 2'd3);
    check("sb_ack", ack, 4'b1000);
    tick();
    req = '0; last = '0;
    #1;
    check("sb_release_gnt", gnt, 4'b0000);
    check("sb_valid", out_valid, 1'b1);
    check("sb_data", out_data, 32'hDEADBEEF);
    check("sb_last", out_last, 1'b1);
    check("sb_src", out_src, 2'd3);
    tick();
    check("sb_drain_valid", out_valid, 1'b0);

    // Round-robin with 2-beat bursts from all four requesters (ptr wrapped to 0)
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      last  = '0;
      din[k] = 32'hA000_0000 | (k << 4) | 1;
      #1;
      check("rr_idle_gnt", gnt, 4'b0000);
      check("rr_idle_ack", ack, 4'b0000);
      tick();
      check("rr_gnt", gnt, 4'b0001 << k);
      check("rr_sel", sel, k);
      check("rr_ack1", ack, 4'b0001 << k);
      tick();
      last   = 4'b1111;
      din[k] = 32'hA000_0000 | (k << 4) | 2;
      #1;
      check("rr_src1", out_src, k);
      check("rr_data1", out_data, 32'hA000_0000 | (k << 4) | 1);
      check("rr_last1", out_last, 1'b0);
      check("rr_ack2", ack, 4'b0001 << k);
      tick();
      check("rr_src2", out_src, k);
      check("rr_data2", out_data, 32'hA000_0000 | (k << 4) | 2);
      check("rr_last2", out_last, 1'b1);
      check("rr_release", gnt, 4'b0000);
    end
    last = '0;
    tick();
    check("rr_wrap_gnt", gnt, 4'b0001);
    last = 4'b0001; din[0] = 32'hA000_0003;
    #1;
    check("rr_wrap_ack", ack, 4'b0001);
    tick();

    // Burst lock: requester 1 holds the mux for 4 beats while 0 and 3 wait (ptr=1)
    req = 4'b1011; last = '0; din[1] = 32'h11;
    #1;
    check("lock_idle_gnt", gnt, 4'b0000);
    tick();
    check("lock_gnt", gnt, 4'b0010);
    check("lock_ack", ack, 4'b0010);
    for (int b = 1; b <= 3; b++) begin
      tick();
      din[1] = 32'h11 + b;
      if (b == 3) last = 4'b0010;
      #1;
      check("lock_data", out_data, 32'h10 + b);
      check("lock_last", out_last, 1'b0);
      check("lock_ack_b", ack, 4'b0010);
    end
    tick();
    req = 4'b1001; last = '0;
    #1;
    check("lock_data4", out_data, 32'h14);
    check("lock_last4", out_last, 1'b1);
    check("lock_release", gnt, 4'b0000);
    tick();
    check("lock_next_gnt", gnt, 4'b1000);
    check("lock_next_sel", sel, 2'd3);

    // Backpressure during requester 3's burst
    din[3] = 32'h31;
    #1;
    check("bp_ack_a", ack, 4'b1000);
    tick();
    out_ready = 1'b0; din[3] = 32'h32;
    #1;
    check("bp_hold_data", out_data, 32'h31);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_no_ack", ack, 4'b0000);
    repeat (2) begin
      tick();
      check("bp_hold_data", out_data, 32'h31);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_no_ack", ack, 4'b0000);
      check("bp_gnt", gnt, 4'b1000);
    end
    tick();
    out_ready = 1'b1;
    #1;
    check("bp_resume_ack", ack, 4'b1000);
    check("bp_resume_data", out_data, 32'h31);
    tick();
    din[3] = 32'h33; last = 4'b1000;
    #1;
    check("bp_data_b", out_data, 32'h32);
    check("bp_last_b", out_last, 1'b0);
    check("bp_ack_c", ack, 4'b1000);
    tick();
    req = 4'b0101; last = '0; din[0] = 32'h01;
    #1;
    check("bp_data_c", out_data, 32'h33);
    check("bp_last_c", out_last, 1'b1);
    check("bp_release", gnt, 4'b0000);

    // Stall timeout on requester 0 (ptr=0), requester 2 waiting
    tick();
    check("to_gnt", gnt, 4'b0001);
    check("to_ack", ack, 4'b0001);
    tick();
    req = 4'b0100;
    #1;
    check("to_data", out_data, 32'h01);
    check("to_valid", out_valid, 1'b1);
    check("to_last", out_last, 1'b0);
    check("to_stall_ack", ack, 4'b0000);
    check("to_hold1", gnt, 4'b0001);
    for (int i = 2; i <= TIMEOUT; i++) begin
      tick();
      check("to_hold", gnt, 4'b0001);
      check("to_valid_clr", out_valid, 1'b0);
    end
    tick();
    check("to_revoke", gnt, 4'b0000);
    check("to_no_last", out_last, 1'b0);
    tick();
    check("to_regrant", gnt, 4'b0100);
    check("to_regrant_ack", ack, 4'b0100);
    last = 4'b0100; din[2] = 32'h22;
    tick();
    req = '0; last = '0;
    #1;
    check("to_r2_data", out_data, 32'h22);
    check("to_r2_src", out_src, 2'd2);
    check("to_r2_last", out_last, 1'b1);

    // Reset in the middle of requester 2's burst (ptr=3 beforehand)
    req = 4'b0100; din[2] = 32'h41;
    tick();
    check("mr_gnt", gnt, 4'b0100);
    tick();
    din[2] = 32'h42;
    #1;
    check("mr_data1", out_data, 32'h41);
    tick();
    check("mr_data2", out_data, 32'h42);
    rst_n = 1'b0;
    #1;
    check("mr_gnt_rst", gnt, 4'b0000);
    check("mr_valid_rst", out_valid, 1'b0);
    check("mr_sel_rst", sel, 2'd0);
    check("mr_data_rst", out_data, 32'h0);
    check("mr_ack_rst", ack, 4'b0000);
    req = 4'b1100;
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_regrant", gnt, 4'b0100);
    last = 4'b0100; din[2] = 32'h43;
    tick();
    req = '0; last = '0;
    #1;
    check("mr_final_data", out_data, 32'h43);
    check("mr_final_last", out_last, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
